// File: rtl/phase_gen.sv
// Front-end for the sine pipeline: streams 64 coefficient writes into the table
// in LOAD mode, and in RUN mode splits an accumulated phase word into table/CORDIC indices.
module phase_gen #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_load,
  input  logic             ld_valid,
  input  logic [47:0]      ld_data,
  output logic             ld_ready,
  input  logic             run,
  input  logic [ACC_W-1:0] ftw,
  input  logic             ftw_we,
  input  logic [15:0]      phase_ofs,
  output logic             busy,
  output logic             cen,
  output logic             wen_trans,
  output logic [5:0]       index_wri,
  output logic [47:0]      D,
  output logic [2:0]       index_qua,
  output logic [5:0]       index_rea,
  output logic [6:0]       index_cor
);

  // state  | meaning
  // S_IDLE | no table access; indices hold
  // S_LOAD | accept ld_data beats, write table entries 0..63
  // S_RUN  | accumulate phase, drive read indices every cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_reg;
  logic [ACC_W-1:0] acc_next;
  logic [5:0]       cnt;
  logic [15:0]      phase;
  logic             accept;

  assign ld_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign accept   = ld_valid & ld_ready;
  assign acc_next = acc + ftw_reg;
  assign phase    = acc_next[ACC_W-1 -: 16] + phase_ofs;

  // Tuning word loads independently of mode; the accumulator sees the old value on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ftw_reg <= '0;
    else if (ftw_we) ftw_reg <= ftw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      cen       <= 1'b0;
      wen_trans <= 1'b0;
      index_wri <= '0;
      D         <= '0;
      index_qua <= '0;
      index_rea <= '0;
      index_cor <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cen       <= 1'b0;
          wen_trans <= 1'b0;
          if (start_load) begin
            state <= S_LOAD;
            acc   <= '0;
            cnt   <= '0;
          end else if (run) begin
            state <= S_RUN;
          end
        end
        S_LOAD: begin
          if (accept) begin
            index_wri <= cnt;
            D         <= ld_data;
            wen_trans <= 1'b1;
            cen       <= 1'b1;
            cnt       <= cnt + 6'd1;
            if (cnt == 6'd63) state <= S_IDLE;
          end else begin
            wen_trans <= 1'b0;
            cen       <= 1'b0;
          end
        end
        S_RUN: begin
          wen_trans <= 1'b0;
          if (start_load) begin
            state <= S_LOAD;
            acc   <= '0;
            cnt   <= '0;
            cen   <= 1'b0;
          end else if (!run) begin
            state <= S_IDLE;
            cen   <= 1'b0;
          end else begin
            acc       <= acc_next;
            index_qua <= phase[15:13];
            index_rea <= phase[12:7];
            index_cor <= phase[6:0];
            cen       <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          cen       <= 1'b0;
          wen_trans <= 1'b0;
        end
      endcase
    end
  end

endmodule
